// File: rtl/ha_serial_sched.sv
// Round-robin arbiter that time-shares one external AND/XOR half-adder cell for WIDTH-bit serial adds.
// Latency: rsp_valid rises 2*WIDTH edges after accept; RESP holds until rsp_ready and no request is accepted meanwhile.
module ha_serial_sched #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_sum,
  output logic                  rsp_cout,
  output logic [IDW-1:0]        rsp_id,
  output logic                  ha_y,
  output logic                  ha_x,
  input  logic                  ha_z,
  input  logic                  ha_w
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PH0  = 2'd1;
  localparam logic [1:0] ST_PH1  = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  logic [1:0]       state;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   cur_id;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] sum_r;
  logic [WIDTH-1:0] sum_nxt;
  logic [BW-1:0]    bit_idx;
  logic             carry;
  logic             carry_nxt;
  logic             p_r;
  logic             g_r;
  logic             win_vld;
  logic [IDW-1:0]   win_id;

  // First valid requester at or after rr_ptr, wrapping around.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (!win_vld && req_valid[(int'(rr_ptr) + j) % NREQ]) begin
        win_vld = 1'b1;
        win_id  = IDW'((int'(rr_ptr) + j) % NREQ);
      end
    end
  end

  // Grant is masked while reset is asserted so nothing looks accepted during reset.
  always_comb begin
    req_ready = '0;
    if (rst_n && state == ST_IDLE && win_vld) req_ready[win_id] = 1'b1;
  end

  always_comb begin
    ha_y = 1'b0;
    ha_x = 1'b0;
    case (state)
      ST_PH0: begin
        ha_y = op_a[bit_idx];
        ha_x = op_b[bit_idx];
      end
      ST_PH1: begin
        ha_y = p_r;
        ha_x = carry;
      end
      default: ;
    endcase
  end

  always_comb begin
    sum_nxt          = sum_r;
    sum_nxt[bit_idx] = ha_w;
  end

  // Full-adder carry: generate from PH0, or propagate-and-carry from PH1.
  assign carry_nxt = g_r | ha_z;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      rr_ptr    <= '0;
      cur_id    <= '0;
      op_a      <= '0;
      op_b      <= '0;
      sum_r     <= '0;
      bit_idx   <= '0;
      carry     <= 1'b0;
      p_r       <= 1'b0;
      g_r       <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
      rsp_id    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (win_vld) begin
            op_a    <= req_a[int'(win_id)*WIDTH +: WIDTH];
            op_b    <= req_b[int'(win_id)*WIDTH +: WIDTH];
            cur_id  <= win_id;
            carry   <= 1'b0;
            bit_idx <= '0;
            rr_ptr  <= (win_id == IDW'(NREQ-1)) ? '0 : win_id + 1'b1;
            state   <= ST_PH0;
          end
        end
        ST_PH0: begin
          p_r   <= ha_w;
          g_r   <= ha_z;
          state <= ST_PH1;
        end
        ST_PH1: begin
          sum_r <= sum_nxt;
          carry <= carry_nxt;
          if (bit_idx == BW'(WIDTH-1)) begin
            rsp_sum   <= sum_nxt;
            rsp_cout  <= carry_nxt;
            rsp_id    <= cur_id;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end else begin
            bit_idx <= bit_idx + 1'b1;
            state   <= ST_PH0;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ha_serial_sched.sv
// Directed bench for ha_serial_sched with a behavioural half-adder cell on ha_y/ha_x.
module tb_ha_serial_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_sum;
  logic        rsp_cout;
  logic [1:0]  rsp_id;
  logic        ha_y;
  logic        ha_x;
  logic        ha_z;
  logic        ha_w;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign ha_z = ha_y & ha_x;
  assign ha_w = ha_y ^ ha_x;

  ha_serial_sched #(.NREQ(4), .WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_id(rsp_id),
    .ha_y(ha_y), .ha_x(ha_x), .ha_z(ha_z), .ha_w(ha_w)
  );

  typedef struct {
    int         id;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] sum;
    logic       cout;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected {ha_y, ha_x} n edges after the accept edge.
  function automatic logic [1:0] ha_exp(input logic [7:0] a, input logic [7:0] b, input int n);
    int k;
    int m;
    logic c;
    k = n / 2;
    if (n % 2 == 0) return {a[k], b[k]};
    m = (1 << k) - 1;
    c = ((((int'(a) & m) + (int'(b) & m)) >> k) & 1) != 0;
    return {a[k] ^ b[k], c};
  endfunction

  task automatic set_req(input int id, input logic [7:0] a, input logic [7:0] b);
    req_a[id*8 +: 8] = a;
    req_b[id*8 +: 8] = b;
    req_valid[id]    = 1'b1;
  endtask

  // Expects id to be granted at the next edge; runs the op to completion and handshakes.
  task automatic finish_op(input int id, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] es, input logic ec, input bit keep, input int hold);
    int n;
    int ha_bad;
    int busy_bad;
    int hold_bad;
    logic [3:0] onehot;
    onehot = 4'b0001 << id;
    chk("grant", req_ready, onehot);
    @(posedge clk); #1;
    if (!keep) req_valid[id] = 1'b0;
    n = 0; ha_bad = 0; busy_bad = 0; hold_bad = 0;
    while (!rsp_valid && n < 40) begin
      if (n < 16 && {ha_y, ha_x} !== ha_exp(a, b, n)) ha_bad++;
      if (req_ready !== 4'b0) busy_bad++;
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, 16);
    chk("ha_seq_errs", ha_bad, 0);
    chk("busy_ready_errs", busy_bad, 0);
    chk("rsp_sum", rsp_sum, es);
    chk("rsp_cout", rsp_cout, ec);
    chk("rsp_id", rsp_id, id);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b1 || rsp_sum !== es || rsp_cout !== ec || rsp_id !== 2'(id)) hold_bad++;
      if (req_ready !== 4'b0 || {ha_y, ha_x} !== 2'b00) hold_bad++;
    end
    if (hold > 0) chk("bp_hold_errs", hold_bad, 0);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", rsp_valid, 1'b0);
    chk("rsp_sum_kept", rsp_sum, es);
  endtask

  initial begin
    tbl[0] = '{2, 8'hA5, 8'h3C, 8'hE1, 1'b0};
    tbl[1] = '{0, 8'hFF, 8'h01, 8'h00, 1'b1};
    tbl[2] = '{1, 8'h00, 8'h00, 8'h00, 1'b0};
    tbl[3] = '{3, 8'h80, 8'h80, 8'h00, 1'b1};
    tbl[4] = '{0, 8'h7F, 8'h01, 8'h80, 1'b0};

    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    #12;
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_req_ready", req_ready, 4'b0);
    chk("rst_ha", {ha_y, ha_x}, 2'b00);
    chk("rst_rsp_fields", {rsp_sum, rsp_cout, rsp_id}, 11'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_no_req_ready", req_ready, 4'b0);

    for (int i = 0; i < 5; i++) begin
      set_req(tbl[i].id, tbl[i].a, tbl[i].b);
      #1;
      finish_op(tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].sum, tbl[i].cout, 1'b0, 0);
    end

    // Backpressure: rr_ptr=1, so 1 beats 3; 3 must wait through the held response.
    set_req(1, 8'h12, 8'h34);
    set_req(3, 8'h01, 8'h02);
    #1;
    finish_op(1, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 5);
    finish_op(3, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0, 0);

    // Reset during PH1 of bit 3 (7 edges after accept); ha_y=1 there.
    set_req(2, 8'h0F, 8'h00);
    #1;
    chk("mid_grant", req_ready, 4'b0100);
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    repeat (7) begin
      @(posedge clk); #1;
    end
    chk("mid_ph1_ha", {ha_y, ha_x}, 2'b10);
    set_req(1, 8'h37, 8'h49);
    set_req(3, 8'hC8, 8'h64);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rsp_valid", rsp_valid, 1'b0);
    chk("mid_rst_req_ready", req_ready, 4'b0);
    chk("mid_rst_ha", {ha_y, ha_x}, 2'b00);
    chk("mid_rst_rsp_sum", rsp_sum, 8'h00);
    #5;
    rst_n = 1'b1;
    #1;
    finish_op(1, 8'h37, 8'h49, 8'h80, 1'b0, 1'b0, 0);
    finish_op(3, 8'hC8, 8'h64, 8'h2C, 1'b1, 1'b0, 0);

    // All four requesters held valid; rr_ptr is 0 here.
    for (int i = 0; i < 4; i++) set_req(i, 8'(i), 8'(16 * i));
    #1;
    finish_op(0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 0);
    finish_op(1, 8'h01, 8'h10, 8'h11, 1'b0, 1'b1, 0);
    finish_op(2, 8'h02, 8'h20, 8'h22, 1'b0, 1'b1, 0);
    finish_op(3, 8'h03, 8'h30, 8'h33, 1'b0, 1'b1, 0);
    finish_op(0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 0);
    req_valid = '0;
    #1;
    chk("rr_next_grant_gone", req_ready, 4'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
